// File: rtl/mac_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// mac_seq_ctrl_if : operand, multiplier and result channels of mac_seq_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mac_seq_ctrl_if #(
  parameter int OP_W   = 256,
  parameter int PROD_W = 512,
  parameter int ACC_W  = 520
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_a;
  logic [OP_W-1:0]   in_b;
  logic              in_first;
  logic              in_last;
  logic [OP_W-1:0]   mul_a;
  logic [OP_W-1:0]   mul_b;
  logic              mul_load_n;
  logic              mul_en;
  logic [PROD_W-1:0] mul_prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic              out_overflow;
  logic              busy;

  modport slave (
    input  in_valid, in_a, in_b, in_first, in_last, mul_prod, out_ready,
    output in_ready, mul_a, mul_b, mul_load_n, mul_en,
           out_valid, out_acc, out_overflow, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_first, in_last, mul_prod, out_ready,
    input  in_ready, mul_a, mul_b, mul_load_n, mul_en,
           out_valid, out_acc, out_overflow, busy
  );
endinterface

`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
// ----------------------------------------------------------------------------
// mac_seq_ctrl : MAC_512 multiplier sequencer and batch accumulator
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mac_seq_ctrl #(
  parameter int OP_W       = 256,
  parameter int PROD_W     = 512,
  parameter int ACC_W      = 520,
  parameter int RUN_CYCLES = 257
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  mac_seq_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(RUN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_ACC  = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic              first_q;
  logic              last_q;
  logic              load_n;
  logic              en;
  logic [ACC_W-1:0]  acc;
  logic              ovf;
  logic [ACC_W-1:0]  base;
  logic [ACC_W:0]    sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.in_valid) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_RUN;
      S_RUN:  if (cnt == CNT_W'(RUN_CYCLES - 1)) state_nxt = S_ACC;
      S_ACC:  state_nxt = last_q ? S_HOLD : S_IDLE;
      S_HOLD: if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One extra bit keeps the carry-out of the batch sum for the sticky overflow.
  assign base = first_q ? '0 : acc;
  assign sum  = {1'b0, base} + (ACC_W + 1)'(bus.mul_prod);

  // Strobes are decoded from the next state so they are registered yet line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      load_n  <= 1'b1;
      en      <= 1'b0;
      acc     <= '0;
      ovf     <= 1'b0;
    end else begin
      load_n <= (state_nxt != S_LOAD);
      en     <= (state_nxt == S_RUN);
      if (state == S_IDLE && bus.in_valid) begin
        op_a    <= bus.in_a;
        op_b    <= bus.in_b;
        first_q <= bus.in_first;
        last_q  <= bus.in_last;
      end
      if (state == S_LOAD) begin
        cnt <= '0;
      end else if (state == S_RUN) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state == S_ACC) begin
        acc <= sum[ACC_W-1:0];
        ovf <= (ovf & ~first_q) | sum[ACC_W];
      end
    end
  end

  assign bus.in_ready     = (state == S_IDLE);
  assign bus.busy         = (state != S_IDLE);
  assign bus.out_valid    = (state == S_HOLD);
  assign bus.out_acc      = acc;
  assign bus.out_overflow = ovf;
  assign bus.mul_a        = op_a;
  assign bus.mul_b        = op_b;
  assign bus.mul_load_n   = load_n;
  assign bus.mul_en       = en;

endmodule

`default_nettype wire

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer and accumulator directly upstream and downstream of the 256-bit shift-add multiplier in the MAC_512 datapath.
- Accepts operand pairs on a valid/ready interface and presents them to the multiplier.
- Pulses the multiplier's load and runs its enable for a fixed cycle count, then samples the 512-bit product.
- Accumulates products over a batch delimited by first/last flags and emits the batch sum on a valid/ready output.

Parameters:
OP_W, 256, operand width (multiplier A/B width)
PROD_W, 512, product width (multiplier output)
ACC_W, 520, accumulator width; must be >= PROD_W
RUN_CYCLES, 257, number of cycles mul_en is held high per product

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset; one clock, asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept a pair (high only in IDLE)
in_a  input  OP_W  multiplicand
in_b  input  OP_W  multiplier
in_first  input  1  pair starts a new batch (clears accumulator)
in_last  input  1  pair ends a batch (result emitted)
mul_a  output  OP_W  multiplicand to multiplier, registered
mul_b  output  OP_W  multiplier operand, registered
mul_load_n  output  1  active-low operand load strobe to multiplier, registered
mul_en  output  1  multiplier step enable, registered
mul_prod  input  PROD_W  multiplier product
out_valid  output  1  batch result valid
out_ready  input  1  downstream accepts result
out_acc  output  ACC_W  batch sum
out_overflow  output  1  sticky: batch sum exceeded ACC_W bits
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: state IDLE, in_ready 1, out_valid 0, out_acc 0, out_overflow 0, mul_en 0, mul_load_n 1, mul_a 0, mul_b 0, busy 0, cycle counter 0.
- Reset asserted mid-operation aborts everything to these values. The in-flight pair and partial sum are discarded.

FSM states and transitions:
- IDLE: in_ready=1.
  - On in_valid && in_ready: register in_a→mul_a, in_b→mul_b, and latch in_first/in_last.
  - Next state LOAD.
- LOAD (1 cycle): mul_load_n=0, mul_en=0. Next state RUN, counter cleared.
- RUN: mul_load_n=1, mul_en=1, counter increments each cycle.
  - At counter==RUN_CYCLES-1 the next state is ACC; mul_en drops to 0 in ACC.
- ACC (1 cycle): sample mul_prod.
  - Compute sum = (first ? 0 : acc) + zero-extended mul_prod, truncated to ACC_W.
  - Carry-out sets overflow; overflow is cleared first when first=1, then ORed with the carry.
  - If last, next state is HOLD; otherwise next state is IDLE.
- HOLD: out_valid=1, out_acc stable. When out_ready=1 the next state is IDLE and out_valid falls the following cycle.

Other rules:
- mul_a and mul_b hold their value from capture until the next capture; they never change during LOAD or RUN.
- Timing, with the handshake at cycle t:
  - LOAD at t+1.
  - RUN at t+2 .. t+1+RUN_CYCLES.
  - ACC at t+2+RUN_CYCLES.
  - out_valid or in_ready high again at t+3+RUN_CYCLES (260 cycles with the defaults).
- in_valid while busy is ignored; the upstream must hold the pair until in_ready.
- in_first and in_last both set means a single-pair batch.
- in_first=1 mid-batch discards the running sum and restarts the batch.
- A batch whose first pair lacks in_first accumulates onto the previous residual sum. This is legal and defined.
- out_acc retains its last value after the handshake until the next ACC update.
- out_overflow is valid alongside out_valid.

Test Plan:
- Single pair: a=3, b=5, first=last=1 -> out_valid exactly 260 cycles after handshake, out_acc=15, out_overflow=0; mul_load_n low exactly 1 cycle; mul_en high exactly 257 cycles.
- Three-pair batch (2*7, 10*10, 1*1), first on pair 0, last on pair 2 -> only one out_valid, out_acc=115; in_ready high for 1 cycle between pairs when in_valid is held high.
- Backpressure: out_ready low 20 cycles during HOLD -> out_valid and out_acc stable, in_ready=0 throughout; handshake returns the block to IDLE next cycle.
- Overflow with ACC_W=512: two pairs of (2^256-1)*(2^256-1) in one batch -> out_overflow=1, out_acc=(2*(2^256-1)^2) mod 2^512. Next batch with first=1, 1*1 -> out_overflow=0, out_acc=1.
- Reset mid-RUN (counter=100) -> all outputs at reset values immediately (asynchronously). After release, a new single pair 4*4 -> out_acc=16.
- in_first mid-batch: pairs 5*5 (first), then 6*6 (first, last) -> out_acc=36.
